timer_bus_sequencer: RTL and testbench

Host-side read/write sequencer for the three-counter 8254 timer. It decodes host bus transactions into per-counter control-word loads and CR byte-write strobes, and keeps the LSB/MSB byte pointers per counter. It also owns the counter-latch, status-latch and read-back command registers, and returns read data to the host. It sits between the host bus and the three counter control/CR/CE instances and is the only block that configures them.

---
 rtl/timer_bus_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_timer_bus_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/timer_bus_sequencer.sv
// Host-side read/write sequencer for a three-counter 8254-style timer.
// Decodes bus transactions into control-word loads, CR byte strobes and read data.
module timer_bus_sequencer #(
    parameter int          N_CNT      = 3,
    parameter logic [7:0]  IDLE_RDATA = 8'h00
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  bus_valid,
    input  logic                  bus_rw,
    input  logic [1:0]            bus_addr,
    input  logic [7:0]            bus_wdata,
    output logic [7:0]            bus_rdata,
    output logic                  bus_rvalid,
    output logic [5:0]            cw_data,
    output logic [N_CNT-1:0]      cw_load,
    output logic [7:0]            cr_wdata,
    output logic [N_CNT-1:0]      cr_write_low,
    output logic [N_CNT-1:0]      cr_write_high,
    input  logic [16*N_CNT-1:0]   count_live,
    input  logic [N_CNT-1:0]      cnt_out,
    input  logic [N_CNT-1:0]      null_count
);

    typedef enum logic {
        PTR_LOW  = 1'b0,
        PTR_HIGH = 1'b1
    } ptr_t;

    logic                reqValid_q;
    logic                reqRw_q;
    logic [1:0]          reqAddr_q;
    logic [7:0]          reqWdata_q;

    logic [5:0]          cfg_q      [N_CNT];
    logic [5:0]          cfg_d      [N_CNT];
    ptr_t                ptr_q      [N_CNT];
    ptr_t                ptr_d      [N_CNT];
    logic [15:0]         latchCnt_q [N_CNT];
    logic [15:0]         latchCnt_d [N_CNT];
    logic [7:0]          status_q   [N_CNT];
    logic [7:0]          status_d   [N_CNT];
    logic [N_CNT-1:0]    cntLatched_q, cntLatched_d;
    logic [N_CNT-1:0]    statLatched_q, statLatched_d;

    logic [7:0]          rdata_q, rdata_d;
    logic                rvalid_q, rvalid_d;
    logic [5:0]          cwData_q, cwData_d;
    logic [N_CNT-1:0]    cwLoad_q, cwLoad_d;
    logic [7:0]          crWdata_q, crWdata_d;
    logic [N_CNT-1:0]    crLow_q, crLow_d;
    logic [N_CNT-1:0]    crHigh_q, crHigh_d;

    logic [1:0]          sc;
    logic [15:0]         srcCnt;

    assign sc = reqWdata_q[7:6];

    // The request is registered first; all decoding acts on the registered copy,
    // which places every pulse and read byte one edge after the sampling edge.
    always_comb begin
        cfg_d         = cfg_q;
        ptr_d         = ptr_q;
        latchCnt_d    = latchCnt_q;
        status_d      = status_q;
        cntLatched_d  = cntLatched_q;
        statLatched_d = statLatched_q;
        rdata_d       = '0;
        rvalid_d      = 1'b0;
        cwData_d      = '0;
        cwLoad_d      = '0;
        crWdata_d     = '0;
        crLow_d       = '0;
        crHigh_d      = '0;
        srcCnt        = '0;

        if (reqValid_q && !reqRw_q && reqAddr_q == 2'd3) begin
            if (sc == 2'b11) begin
                // Read-back: COUNT_n and STATUS_n are active low; mask bit i+1 selects counter i.
                for (int i = 0; i < N_CNT; i++) begin
                    if (reqWdata_q[i+1]) begin
                        if (!reqWdata_q[5] && !cntLatched_q[i]) begin
                            latchCnt_d[i]   = count_live[16*i +: 16];
                            cntLatched_d[i] = 1'b1;
                        end
                        if (!reqWdata_q[4] && !statLatched_q[i]) begin
                            status_d[i]      = {cnt_out[i], null_count[i], cfg_q[i]};
                            statLatched_d[i] = 1'b1;
                        end
                    end
                end
            end else begin
                for (int i = 0; i < N_CNT; i++) begin
                    if (sc == 2'(i)) begin
                        if (reqWdata_q[5:4] == 2'b00) begin
                            if (!cntLatched_q[i]) begin
                                latchCnt_d[i]   = count_live[16*i +: 16];
                                cntLatched_d[i] = 1'b1;
                            end
                        end else begin
                            cfg_d[i]         = reqWdata_q[5:0];
                            cwData_d         = reqWdata_q[5:0];
                            cwLoad_d[i]      = 1'b1;
                            ptr_d[i]         = PTR_LOW;
                            cntLatched_d[i]  = 1'b0;
                            statLatched_d[i] = 1'b0;
                        end
                    end
                end
            end
        end else if (reqValid_q && !reqRw_q) begin
            crWdata_d = reqWdata_q;
            for (int i = 0; i < N_CNT; i++) begin
                if (reqAddr_q == 2'(i)) begin
                    case (cfg_q[i][5:4])
                        2'b01: crLow_d[i] = 1'b1;
                        2'b10: crHigh_d[i] = 1'b1;
                        2'b11: begin
                            if (ptr_q[i] == PTR_LOW) begin
                                crLow_d[i] = 1'b1;
                                ptr_d[i]   = PTR_HIGH;
                            end else begin
                                crHigh_d[i] = 1'b1;
                                ptr_d[i]    = PTR_LOW;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end else if (reqValid_q) begin
            rvalid_d = 1'b1;
            rdata_d  = IDLE_RDATA;
            // Read source priority: latched status, then latched count, then the live count.
            for (int i = 0; i < N_CNT; i++) begin
                if (reqAddr_q == 2'(i)) begin
                    srcCnt = cntLatched_q[i] ? latchCnt_q[i] : count_live[16*i +: 16];
                    if (statLatched_q[i]) begin
                        rdata_d          = status_q[i];
                        statLatched_d[i] = 1'b0;
                    end else begin
                        case (cfg_q[i][5:4])
                            2'b01: begin
                                rdata_d         = srcCnt[7:0];
                                cntLatched_d[i] = 1'b0;
                            end
                            2'b10: begin
                                rdata_d         = srcCnt[15:8];
                                cntLatched_d[i] = 1'b0;
                            end
                            2'b11: begin
                                if (ptr_q[i] == PTR_LOW) begin
                                    rdata_d  = srcCnt[7:0];
                                    ptr_d[i] = PTR_HIGH;
                                end else begin
                                    rdata_d         = srcCnt[15:8];
                                    ptr_d[i]        = PTR_LOW;
                                    cntLatched_d[i] = 1'b0;
                                end
                            end
                            default: rdata_d = IDLE_RDATA;
                        endcase
                    end
                end
            end
        end
    end

    // Reset discards the pending request, every latch and the programmed modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reqValid_q    <= 1'b0;
            reqRw_q       <= 1'b0;
            reqAddr_q     <= '0;
            reqWdata_q    <= '0;
            for (int i = 0; i < N_CNT; i++) begin
                cfg_q[i]      <= '0;
                ptr_q[i]      <= PTR_LOW;
                latchCnt_q[i] <= '0;
                status_q[i]   <= '0;
            end
            cntLatched_q  <= '0;
            statLatched_q <= '0;
            rdata_q       <= '0;
            rvalid_q      <= 1'b0;
            cwData_q      <= '0;
            cwLoad_q      <= '0;
            crWdata_q     <= '0;
            crLow_q       <= '0;
            crHigh_q      <= '0;
        end else begin
            reqValid_q    <= bus_valid;
            reqRw_q       <= bus_rw;
            reqAddr_q     <= bus_addr;
            reqWdata_q    <= bus_wdata;
            for (int i = 0; i < N_CNT; i++) begin
                cfg_q[i]      <= cfg_d[i];
                ptr_q[i]      <= ptr_d[i];
                latchCnt_q[i] <= latchCnt_d[i];
                status_q[i]   <= status_d[i];
            end
            cntLatched_q  <= cntLatched_d;
            statLatched_q <= statLatched_d;
            rdata_q       <= rdata_d;
            rvalid_q      <= rvalid_d;
            cwData_q      <= cwData_d;
            cwLoad_q      <= cwLoad_d;
            crWdata_q     <= crWdata_d;
            crLow_q       <= crLow_d;
            crHigh_q      <= crHigh_d;
        end
    end

    assign bus_rdata     = rdata_q;
    assign bus_rvalid    = rvalid_q;
    assign cw_data       = cwData_q;
    assign cw_load       = cwLoad_q;
    assign cr_wdata      = crWdata_q;
    assign cr_write_low  = crLow_q;
    assign cr_write_high = crHigh_q;

endmodule

// File: tb/tb_timer_bus_sequencer.sv
// Directed bench for timer_bus_sequencer: programming, count/status latching,
// byte pointer sequencing and mid-sequence reset.
module tb_timer_bus_sequencer;

    logic        clk;
    logic        rst_n;
    logic        bus_valid;
    logic        bus_rw;
    logic [1:0]  bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_rvalid;
    logic [5:0]  cw_data;
    logic [2:0]  cw_load;
    logic [7:0]  cr_wdata;
    logic [2:0]  cr_write_low;
    logic [2:0]  cr_write_high;
    logic [47:0] count_live;
    logic [2:0]  cnt_out;
    logic [2:0]  null_count;

    int numChecks = 0;
    int numFails  = 0;

    timer_bus_sequencer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus_valid     (bus_valid),
        .bus_rw        (bus_rw),
        .bus_addr      (bus_addr),
        .bus_wdata     (bus_wdata),
        .bus_rdata     (bus_rdata),
        .bus_rvalid    (bus_rvalid),
        .cw_data       (cw_data),
        .cw_load       (cw_load),
        .cr_wdata      (cr_wdata),
        .cr_write_low  (cr_write_low),
        .cr_write_high (cr_write_high),
        .count_live    (count_live),
        .cnt_out       (cnt_out),
        .null_count    (null_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [47:0] observed, input logic [47:0] expected);
        numChecks++;
        if (observed !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One bus cycle sampled at edge k; returns #1 after edge k+1 when its outputs are visible.
    task automatic applyStimulus(input logic rw, input logic [1:0] addr, input logic [7:0] wdata);
        @(negedge clk);
        bus_valid = 1'b1;
        bus_rw    = rw;
        bus_addr  = addr;
        bus_wdata = wdata;
        @(negedge clk);
        bus_valid = 1'b0;
        bus_rw    = 1'b0;
        bus_addr  = 2'd0;
        bus_wdata = 8'h00;
        @(posedge clk);
        #1;
    endtask

    task automatic readCheck(input string tag, input logic [1:0] addr, input logic [7:0] expected);
        applyStimulus(1'b1, addr, 8'h00);
        checkOutput({tag, "_rvalid"}, 48'(bus_rvalid), 48'd1);
        checkOutput(tag, 48'(bus_rdata), 48'(expected));
    endtask

    initial begin
        rst_n      = 1'b0;
        bus_valid  = 1'b0;
        bus_rw     = 1'b0;
        bus_addr   = 2'd0;
        bus_wdata  = 8'h00;
        count_live = 48'h0;
        cnt_out    = 3'b000;
        null_count = 3'b000;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rdata", 48'(bus_rdata), 48'h0);
        checkOutput("reset_rvalid", 48'(bus_rvalid), 48'h0);
        checkOutput("reset_cw", 48'({cw_data, cw_load}), 48'h0);
        checkOutput("reset_cr", 48'({cr_wdata, cr_write_low, cr_write_high}), 48'h0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] counter 0 programming, RW=11 mode 2");
        applyStimulus(1'b0, 2'd3, 8'h34);
        checkOutput("cw0_load", 48'(cw_load), 48'b001);
        checkOutput("cw0_data", 48'(cw_data), 48'h34);
        @(posedge clk);
        #1;
        checkOutput("cw0_load_one_cycle", 48'(cw_load), 48'b000);
        applyStimulus(1'b0, 2'd0, 8'h10);
        checkOutput("cr0_low_pulse", 48'({cr_write_low, cr_write_high}), 48'b001_000);
        checkOutput("cr0_low_data", 48'(cr_wdata), 48'h10);
        applyStimulus(1'b0, 2'd0, 8'h27);
        checkOutput("cr0_high_pulse", 48'({cr_write_low, cr_write_high}), 48'b000_001);
        checkOutput("cr0_high_data", 48'(cr_wdata), 48'h27);

        $display("[TB] counter 0 count latch");
        count_live[15:0] = 16'h1234;
        applyStimulus(1'b0, 2'd3, 8'h00);
        checkOutput("latch_no_cwload", 48'(cw_load), 48'b000);
        count_live[15:0] = 16'h1200;
        readCheck("latch_lsb", 2'd0, 8'h34);
        @(posedge clk);
        #1;
        checkOutput("rvalid_one_cycle", 48'(bus_rvalid), 48'd0);
        readCheck("latch_msb", 2'd0, 8'h12);
        readCheck("live_lsb", 2'd0, 8'h00);
        readCheck("live_msb", 2'd0, 8'h12);

        $display("[TB] repeated latch command is ignored");
        count_live[15:0] = 16'h1234;
        applyStimulus(1'b0, 2'd3, 8'h00);
        count_live[15:0] = 16'h5555;
        applyStimulus(1'b0, 2'd3, 8'h00);
        readCheck("relatch_lsb", 2'd0, 8'h34);
        readCheck("relatch_msb", 2'd0, 8'h12);

        $display("[TB] counter 1 read-back of status and count");
        applyStimulus(1'b0, 2'd3, 8'h76);
        checkOutput("cw1_load", 48'(cw_load), 48'b010);
        checkOutput("cw1_data", 48'(cw_data), 48'h36);
        count_live = {16'h7788, 16'hABCD, 16'h5555};
        cnt_out    = 3'b010;
        null_count = 3'b000;
        applyStimulus(1'b0, 2'd3, 8'hC4);
        count_live[31:16] = 16'h0000;
        readCheck("rb_status", 2'd1, 8'hB6);
        readCheck("rb_count_lsb", 2'd1, 8'hCD);
        readCheck("rb_count_msb", 2'd1, 8'hAB);
        readCheck("rb_live_after", 2'd1, 8'h00);
        readCheck("rb_cnt0_unselected", 2'd0, 8'h55);

        $display("[TB] counter 2 RW=01 low-byte only");
        applyStimulus(1'b0, 2'd3, 8'h90);
        checkOutput("cw2_load", 48'(cw_load), 48'b100);
        checkOutput("cw2_data", 48'(cw_data), 48'h10);
        applyStimulus(1'b0, 2'd2, 8'hAA);
        checkOutput("cr2_first", 48'({cr_write_low, cr_write_high}), 48'b100_000);
        checkOutput("cr2_first_data", 48'(cr_wdata), 48'hAA);
        applyStimulus(1'b0, 2'd2, 8'hAA);
        checkOutput("cr2_second", 48'({cr_write_low, cr_write_high}), 48'b100_000);
        readCheck("cnt2_lsb_only", 2'd2, 8'h88);
        readCheck("addr3_read_idle", 2'd3, 8'h00);

        $display("[TB] reset between low and high byte writes");
        applyStimulus(1'b0, 2'd3, 8'h34);
        applyStimulus(1'b0, 2'd0, 8'h10);
        checkOutput("pre_reset_low", 48'(cr_write_low), 48'b001);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_cr", 48'({cr_wdata, cr_write_low, cr_write_high}), 48'h0);
        checkOutput("async_reset_other", 48'({bus_rdata, bus_rvalid, cw_data, cw_load}), 48'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'd0, 8'h27);
        checkOutput("post_reset_no_pulse", 48'({cr_write_low, cr_write_high}), 48'h0);
        readCheck("post_reset_read_idle", 2'd0, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
        $finish;
    end

endmodule
